// File: rtl/mem_arbiter_nxm.sv
// mem_arbiter_nxm: multiplexes READ_MASTERS read and WRITE_MASTERS write clients onto one AXI port
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise lowest eligible index wins.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_m_ar* / o_m_arready      per-read-client AR channel, packed by client index
//   o_m_r* / i_m_rready        per-read-client R channel (valid per client, data/last/id shared)
//   i_w_aw* / o_w_awready      per-write-client AW channel
//   i_w_w* / o_w_wready        per-write-client W channel
//   o_w_b* / i_w_bready        per-write-client B channel (valid per client, id shared)
//   o_ar*/i_r*/o_aw*/o_w*/i_b* external AXI channels; downstream IDs carry the client index
//   o_rd_busy, o_wr_state      outstanding-read flags and write FSM state
module mem_arbiter_nxm #(
    parameter int READ_MASTERS  = 2,
    parameter int WRITE_MASTERS = 1,
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int LEN_W         = 8,
    parameter int M_ID_W        = 4,
    parameter int AXI_ID_W      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [READ_MASTERS-1:0]               i_m_arvalid,
    input  logic [READ_MASTERS-1:0][ADDR_W-1:0]   i_m_araddr,
    input  logic [READ_MASTERS-1:0][LEN_W-1:0]    i_m_arlen,
    input  logic [READ_MASTERS-1:0][M_ID_W-1:0]   i_m_arid,
    output logic [READ_MASTERS-1:0]               o_m_arready,
    output logic [READ_MASTERS-1:0]               o_m_rvalid,
    output logic [DATA_W-1:0]                     o_m_rdata,
    output logic                                  o_m_rlast,
    output logic [M_ID_W-1:0]                     o_m_rid,
    input  logic [READ_MASTERS-1:0]               i_m_rready,
    input  logic [WRITE_MASTERS-1:0]              i_w_awvalid,
    input  logic [WRITE_MASTERS-1:0][ADDR_W-1:0]  i_w_awaddr,
    input  logic [WRITE_MASTERS-1:0][LEN_W-1:0]   i_w_awlen,
    input  logic [WRITE_MASTERS-1:0][M_ID_W-1:0]  i_w_awid,
    output logic [WRITE_MASTERS-1:0]              o_w_awready,
    input  logic [WRITE_MASTERS-1:0]              i_w_wvalid,
    input  logic [WRITE_MASTERS-1:0][DATA_W-1:0]  i_w_wdata,
    input  logic [WRITE_MASTERS-1:0]              i_w_wlast,
    output logic [WRITE_MASTERS-1:0]              o_w_wready,
    output logic [WRITE_MASTERS-1:0]              o_w_bvalid,
    output logic [M_ID_W-1:0]                     o_w_bid,
    input  logic [WRITE_MASTERS-1:0]              i_w_bready,
    output logic                                  o_arvalid,
    output logic [ADDR_W-1:0]                     o_araddr,
    output logic [LEN_W-1:0]                      o_arlen,
    output logic [AXI_ID_W-1:0]                   o_arid,
    input  logic                                  i_arready,
    input  logic                                  i_rvalid,
    input  logic [DATA_W-1:0]                     i_rdata,
    input  logic                                  i_rlast,
    input  logic [AXI_ID_W-1:0]                   i_rid,
    output logic                                  o_rready,
    output logic                                  o_awvalid,
    output logic [ADDR_W-1:0]                     o_awaddr,
    output logic [LEN_W-1:0]                      o_awlen,
    output logic [AXI_ID_W-1:0]                   o_awid,
    input  logic                                  i_awready,
    output logic                                  o_wvalid,
    output logic [DATA_W-1:0]                     o_wdata,
    output logic                                  o_wlast,
    output logic [AXI_ID_W-1:0]                   o_wid,
    input  logic                                  i_wready,
    input  logic                                  i_bvalid,
    input  logic [AXI_ID_W-1:0]                   i_bid,
    output logic                                  o_bready,
    output logic [READ_MASTERS-1:0]               o_rd_busy,
    output logic [1:0]                            o_wr_state
);
    localparam int MAX_M = (READ_MASTERS > WRITE_MASTERS) ?
                           ((READ_MASTERS > 2) ? READ_MASTERS : 2) :
                           ((WRITE_MASTERS > 2) ? WRITE_MASTERS : 2);
    localparam int IDX_W = $clog2(MAX_M);
    localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;

    // Lowest requester at or above ptr wins; if none, the lowest requester overall (wrap).
    function automatic logic [IDX_W-1:0] pick(input logic [MAX_M-1:0] req, input logic [IDX_W-1:0] ptr);
        pick = '0;
        for (int j = MAX_M - 1; j >= 0; j--) if (req[j]) pick = IDX_W'(j);
        for (int j = MAX_M - 1; j >= 0; j--) if (req[j] && IDX_W'(j) >= ptr) pick = IDX_W'(j);
    endfunction

    logic [READ_MASTERS-1:0]              r_busy;
    logic                                 r_ar_valid;
    logic [IDX_W-1:0]                     r_ar_owner;
    logic [ADDR_W-1:0]                    r_ar_addr;
    logic [LEN_W-1:0]                     r_ar_len;
    logic [READ_MASTERS-1:0][M_ID_W-1:0]  r_saved_arid;
    logic [READ_MASTERS-1:0]              w_rd_elig;
    logic [READ_MASTERS-1:0]              w_rd_clr;
    logic [IDX_W-1:0]                     w_rd_win;
    logic [IDX_W-1:0]                     w_rd_ptr;
    logic                                 w_rd_go;

    logic [1:0]                           r_wr_state;
    logic [IDX_W-1:0]                     r_wr_owner;
    logic [ADDR_W-1:0]                    r_wr_addr;
    logic [LEN_W-1:0]                     r_wr_len;
    logic [M_ID_W-1:0]                    r_wr_awid;
    logic [1:0]                           w_wr_next;
    logic [IDX_W-1:0]                     w_wr_win;
    logic [IDX_W-1:0]                     w_wr_ptr;
    logic                                 w_wr_go;
    logic                                 w_wr_data;
    logic                                 w_bmatch;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_rd_ptr;
    logic [IDX_W-1:0] r_wr_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_rd_go) r_rd_ptr <= (w_rd_win == IDX_W'(READ_MASTERS - 1)) ? '0 : w_rd_win + IDX_W'(1);
            if (w_wr_go) r_wr_ptr <= (w_wr_win == IDX_W'(WRITE_MASTERS - 1)) ? '0 : w_wr_win + IDX_W'(1);
        end
    end
    assign w_rd_ptr = r_rd_ptr;
    assign w_wr_ptr = r_wr_ptr;
`else
    assign w_rd_ptr = '0;
    assign w_wr_ptr = '0;
`endif

    // Read address: one-entry AR stage, refillable in the same cycle it drains downstream.
    // Grants are gated by rst_n so no READY can pulse while reset is held.
    assign w_rd_elig   = i_m_arvalid & ~r_busy;
    assign w_rd_win    = pick(MAX_M'(w_rd_elig), w_rd_ptr);
    assign w_rd_go     = rst_n && (|w_rd_elig) && (!r_ar_valid || i_arready);
    assign o_m_arready = w_rd_go ? (READ_MASTERS'(1) << w_rd_win) : '0;
    assign o_arvalid   = r_ar_valid;
    assign o_araddr    = r_ar_addr;
    assign o_arlen     = r_ar_len;
    assign o_arid      = AXI_ID_W'(r_ar_owner);
    assign o_rd_busy   = r_busy;

    // R routing: only an ID naming a busy client is forwarded; anything else is sunk.
    always_comb begin
        o_m_rvalid = '0;
        o_m_rid    = '0;
        o_rready   = 1'b1;
        w_rd_clr   = '0;
        for (int j = 0; j < READ_MASTERS; j++) begin
            if (i_rid == AXI_ID_W'(j) && r_busy[j]) begin
                o_m_rvalid[j] = i_rvalid;
                o_m_rid       = r_saved_arid[j];
                o_rready      = i_m_rready[j];
                w_rd_clr[j]   = i_rvalid & i_m_rready[j] & i_rlast;
            end
        end
    end
    assign o_m_rdata = i_rdata;
    assign o_m_rlast = i_rlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_ar_valid   <= 1'b0;
            r_ar_owner   <= '0;
            r_ar_addr    <= '0;
            r_ar_len     <= '0;
            r_saved_arid <= '0;
        end else begin
            r_busy <= (r_busy | o_m_arready) & ~w_rd_clr;
            if (w_rd_go) begin
                r_ar_valid             <= 1'b1;
                r_ar_owner             <= w_rd_win;
                r_ar_addr              <= i_m_araddr[w_rd_win];
                r_ar_len               <= i_m_arlen[w_rd_win];
                r_saved_arid[w_rd_win] <= i_m_arid[w_rd_win];
            end else if (i_arready) begin
                r_ar_valid <= 1'b0;
            end
        end
    end

    // Write path: one burst at a time through AW, W and B phases.
    assign w_wr_win    = pick(MAX_M'(i_w_awvalid), w_wr_ptr);
    assign w_wr_go     = rst_n && (r_wr_state == W_IDLE) && (|i_w_awvalid);
    assign w_wr_data   = r_wr_state == W_DATA;
    assign w_bmatch    = (r_wr_state == W_RESP) && (i_bid == AXI_ID_W'(r_wr_owner));
    assign o_w_awready = w_wr_go ? (WRITE_MASTERS'(1) << w_wr_win) : '0;
    assign o_awvalid   = r_wr_state == W_ADDR;
    assign o_awaddr    = r_wr_addr;
    assign o_awlen     = r_wr_len;
    assign o_awid      = AXI_ID_W'(r_wr_owner);
    assign o_wvalid    = w_wr_data & i_w_wvalid[r_wr_owner];
    assign o_wdata     = i_w_wdata[r_wr_owner];
    assign o_wlast     = i_w_wlast[r_wr_owner];
    assign o_wid       = AXI_ID_W'(r_wr_owner);
    assign o_w_wready  = (w_wr_data && i_wready) ? (WRITE_MASTERS'(1) << r_wr_owner) : '0;
    assign o_bready    = w_bmatch ? i_w_bready[r_wr_owner] : 1'b1;
    assign o_w_bvalid  = (w_bmatch && i_bvalid) ? (WRITE_MASTERS'(1) << r_wr_owner) : '0;
    assign o_w_bid     = r_wr_awid;
    assign o_wr_state  = r_wr_state;

    assign w_wr_next = (r_wr_state == W_IDLE) ? (w_wr_go ? W_ADDR : W_IDLE) :
                       (r_wr_state == W_ADDR) ? (i_awready ? W_DATA : W_ADDR) :
                       (r_wr_state == W_DATA) ? ((o_wvalid && i_wready && o_wlast) ? W_RESP : W_DATA) :
                       ((w_bmatch && i_bvalid && o_bready) ? W_IDLE : W_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_owner <= '0;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            r_wr_awid  <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_wr_go) begin
                r_wr_owner <= w_wr_win;
                r_wr_addr  <= i_w_awaddr[w_wr_win];
                r_wr_len   <= i_w_awlen[w_wr_win];
                r_wr_awid  <= i_w_awid[w_wr_win];
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_nxm.sv
// tb_mem_arbiter_nxm: directed self-checking bench for mem_arbiter_nxm (2 read clients, 1 write client)
module tb_mem_arbiter_nxm;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]        m_arvalid = '0;
    logic [1:0][31:0]  m_araddr = '0;
    logic [1:0][7:0]   m_arlen = '0;
    logic [1:0][3:0]   m_arid = '0;
    logic [1:0]        m_rready = '0;
    logic [0:0]        w_awvalid = '0;
    logic [0:0][31:0]  w_awaddr = '0;
    logic [0:0][7:0]   w_awlen = '0;
    logic [0:0][3:0]   w_awid = '0;
    logic [0:0]        w_wvalid = '0;
    logic [0:0][31:0]  w_wdata = '0;
    logic [0:0]        w_wlast = '0;
    logic [0:0]        w_bready = '0;
    logic              arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]       rdata = '0;
    logic [3:0]        rid = '0, bid = '0;

    logic [1:0]  o_m_arready, o_m_rvalid, o_rd_busy;
    logic [31:0] o_m_rdata, o_araddr, o_awaddr, o_wdata;
    logic        o_m_rlast, o_arvalid, o_rready, o_awvalid, o_wvalid, o_wlast, o_bready;
    logic [3:0]  o_m_rid, o_w_bid, o_arid, o_awid, o_wid;
    logic [0:0]  o_w_awready, o_w_wready, o_w_bvalid;
    logic [7:0]  o_arlen, o_awlen;
    logic [1:0]  o_wr_state;

    int vec = 0;
    int errs = 0;

    mem_arbiter_nxm dut (
        .clk(clk), .rst_n(rst_n),
        .i_m_arvalid(m_arvalid), .i_m_araddr(m_araddr), .i_m_arlen(m_arlen), .i_m_arid(m_arid),
        .o_m_arready(o_m_arready), .o_m_rvalid(o_m_rvalid), .o_m_rdata(o_m_rdata), .o_m_rlast(o_m_rlast),
        .o_m_rid(o_m_rid), .i_m_rready(m_rready),
        .i_w_awvalid(w_awvalid), .i_w_awaddr(w_awaddr), .i_w_awlen(w_awlen), .i_w_awid(w_awid),
        .o_w_awready(o_w_awready), .i_w_wvalid(w_wvalid), .i_w_wdata(w_wdata), .i_w_wlast(w_wlast),
        .o_w_wready(o_w_wready), .o_w_bvalid(o_w_bvalid), .o_w_bid(o_w_bid), .i_w_bready(w_bready),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arid(o_arid), .i_arready(arready),
        .i_rvalid(rvalid), .i_rdata(rdata), .i_rlast(rlast), .i_rid(rid), .o_rready(o_rready),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awid(o_awid), .i_awready(awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wlast(o_wlast), .o_wid(o_wid), .i_wready(wready),
        .i_bvalid(bvalid), .i_bid(bid), .o_bready(o_bready),
        .o_rd_busy(o_rd_busy), .o_wr_state(o_wr_state)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_arvalid = 2'b11;
        w_awvalid = 1'b1;
        #3;
        vec++; if ({o_m_arready, o_w_awready, o_w_wready, o_m_rvalid, o_w_bvalid, o_arvalid, o_awvalid, o_wvalid} !== 10'd0) begin errs++; $display("FAIL reset_outputs: got %h want 0", {o_m_arready, o_w_awready, o_w_wready, o_m_rvalid, o_w_bvalid, o_arvalid, o_awvalid, o_wvalid}); end
        repeat (2) @(posedge clk);
        #1;
        vec++; if ({o_m_arready, o_w_awready, o_arvalid, o_awvalid, o_rd_busy, o_wr_state} !== 8'd0) begin errs++; $display("FAIL reset_held: got %h want 0", {o_m_arready, o_w_awready, o_arvalid, o_awvalid, o_rd_busy, o_wr_state}); end
        m_arvalid = 2'b00;
        w_awvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_read_single();
        nxt();
        m_arvalid = 2'b01; m_araddr[0] = 32'h100; m_arlen[0] = 8'd3; m_arid[0] = 4'd5; arready = 1'b0;
        #1;
        vec++; if (o_m_arready !== 2'b01) begin errs++; $display("FAIL rd1_grant: got %b want 01", o_m_arready); end
        vec++; if (o_arvalid !== 1'b0) begin errs++; $display("FAIL rd1_arvalid_t: got %b want 0", o_arvalid); end
        nxt();
        m_arvalid = 2'b00;
        #1;
        vec++; if ({o_arvalid, o_araddr, o_arlen, o_arid} !== {1'b1, 32'h100, 8'd3, 4'd0}) begin errs++; $display("FAIL rd1_ar_fields: got %h want %h", {o_arvalid, o_araddr, o_arlen, o_arid}, {1'b1, 32'h100, 8'd3, 4'd0}); end
        vec++; if ({o_m_arready, o_rd_busy} !== 4'b0001) begin errs++; $display("FAIL rd1_busy: got %b want 0001", {o_m_arready, o_rd_busy}); end
        arready = 1'b1;
        nxt();
        arready = 1'b0;
        #1;
        vec++; if (o_arvalid !== 1'b0) begin errs++; $display("FAIL rd1_ar_drain: got %b want 0", o_arvalid); end
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'(32'hA0 + b); rlast = (b == 3); m_rready = 2'b01;
            #1;
            vec++; if ({o_m_rvalid, o_m_rid, o_m_rdata, o_m_rlast, o_rready} !== {2'b01, 4'd5, 32'(32'hA0 + b), (b == 3), 1'b1}) begin errs++; $display("FAIL rd1_beat%0d: got %h want %h", b, {o_m_rvalid, o_m_rid, o_m_rdata, o_m_rlast, o_rready}, {2'b01, 4'd5, 32'(32'hA0 + b), (b == 3), 1'b1}); end
            vec++; if (o_rd_busy !== 2'b01) begin errs++; $display("FAIL rd1_busy_beat%0d: got %b want 01", b, o_rd_busy); end
            nxt();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vec++; if (o_rd_busy !== 2'b00) begin errs++; $display("FAIL rd1_busy_clear: got %b want 00", o_rd_busy); end
    endtask

    task automatic test_priority();
        logic [1:0] g1, g2;
        g1 = 2'b01 << FIRST;
        g2 = 2'b01 << (1 - FIRST);
        nxt();
        m_arvalid = 2'b11; arready = 1'b1;
        m_araddr[0] = 32'h300; m_arid[0] = 4'd1; m_arlen[0] = 8'd0;
        m_araddr[1] = 32'h400; m_arid[1] = 4'd2; m_arlen[1] = 8'd0;
        #1;
        vec++; if (o_m_arready !== g1) begin errs++; $display("FAIL prio_first: got %b want %b", o_m_arready, g1); end
        nxt();
        m_arvalid = g2;
        #1;
        vec++; if (o_m_arready !== g2) begin errs++; $display("FAIL prio_second: got %b want %b", o_m_arready, g2); end
        vec++; if (o_arid !== 4'(FIRST)) begin errs++; $display("FAIL prio_arid1: got %0d want %0d", o_arid, FIRST); end
        nxt();
        m_arvalid = 2'b00;
        #1;
        vec++; if ({o_arvalid, o_arid, o_araddr, o_rd_busy} !== {1'b1, 4'(1 - FIRST), (FIRST == 1) ? 32'h300 : 32'h400, 2'b11}) begin errs++; $display("FAIL prio_arid2: got %h want %h", {o_arvalid, o_arid, o_araddr, o_rd_busy}, {1'b1, 4'(1 - FIRST), (FIRST == 1) ? 32'h300 : 32'h400, 2'b11}); end
        nxt();
    endtask

    task automatic test_out_of_order();
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hB0; rlast = 1'b0; m_rready = 2'b01;
        #1;
        vec++; if ({o_m_rvalid, o_rready} !== 3'b100) begin errs++; $display("FAIL ooo_stall: got %b want 100", {o_m_rvalid, o_rready}); end
        nxt();
        m_rready = 2'b11;
        #1;
        vec++; if ({o_m_rvalid, o_m_rid, o_rready} !== {2'b10, 4'd2, 1'b1}) begin errs++; $display("FAIL ooo_m1_beat0: got %h want %h", {o_m_rvalid, o_m_rid, o_rready}, {2'b10, 4'd2, 1'b1}); end
        nxt();
        rdata = 32'hB1; rlast = 1'b1;
        m_arvalid = 2'b10; m_araddr[1] = 32'h500; m_arid[1] = 4'd6;
        #1;
        vec++; if (o_m_rvalid !== 2'b10) begin errs++; $display("FAIL ooo_m1_last: got %b want 10", o_m_rvalid); end
        vec++; if (o_m_arready !== 2'b00) begin errs++; $display("FAIL ooo_busy_inelig: got %b want 00", o_m_arready); end
        nxt();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vec++; if ({o_rd_busy, o_m_arready} !== 4'b0110) begin errs++; $display("FAIL ooo_reelig: got %b want 0110", {o_rd_busy, o_m_arready}); end
        nxt();
        m_arvalid = 2'b00;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hC0; rlast = 1'b1;
        #1;
        vec++; if ({o_m_rvalid, o_m_rid} !== {2'b01, 4'd1}) begin errs++; $display("FAIL ooo_m0_beat: got %h want %h", {o_m_rvalid, o_m_rid}, {2'b01, 4'd1}); end
        nxt();
        rid = 4'd1; rdata = 32'hC1;
        #1;
        vec++; if ({o_m_rvalid, o_m_rid} !== {2'b10, 4'd6}) begin errs++; $display("FAIL ooo_m1_new: got %h want %h", {o_m_rvalid, o_m_rid}, {2'b10, 4'd6}); end
        nxt();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vec++; if ({o_rd_busy, o_arvalid} !== 3'b000) begin errs++; $display("FAIL ooo_drain: got %b want 000", {o_rd_busy, o_arvalid}); end
    endtask

    task automatic test_stray();
        nxt();
        rvalid = 1'b1; rid = 4'd7; rlast = 1'b1; m_rready = 2'b00;
        #1;
        vec++; if ({o_rready, o_m_rvalid} !== 3'b100) begin errs++; $display("FAIL stray_rid7: got %b want 100", {o_rready, o_m_rvalid}); end
        nxt();
        rid = 4'd0;
        #1;
        vec++; if ({o_rready, o_m_rvalid} !== 3'b100) begin errs++; $display("FAIL stray_idle_rid0: got %b want 100", {o_rready, o_m_rvalid}); end
        nxt();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        vec++; if (o_rd_busy !== 2'b00) begin errs++; $display("FAIL stray_busy: got %b want 00", o_rd_busy); end
    endtask

    task automatic test_write();
        nxt();
        w_awvalid = 1'b1; w_awaddr[0] = 32'h200; w_awlen[0] = 8'd1; w_awid[0] = 4'd3; awready = 1'b0;
        #1;
        vec++; if ({o_w_awready, o_wr_state, o_awvalid} !== 4'b1000) begin errs++; $display("FAIL wr_grant: got %b want 1000", {o_w_awready, o_wr_state, o_awvalid}); end
        nxt();
        w_awvalid = 1'b0;
        #1;
        vec++; if ({o_wr_state, o_awvalid, o_awaddr, o_awlen, o_awid, o_w_awready} !== {2'd1, 1'b1, 32'h200, 8'd1, 4'd0, 1'b0}) begin errs++; $display("FAIL wr_addr: got %h want %h", {o_wr_state, o_awvalid, o_awaddr, o_awlen, o_awid, o_w_awready}, {2'd1, 1'b1, 32'h200, 8'd1, 4'd0, 1'b0}); end
        awready = 1'b1;
        nxt();
        awready = 1'b0;
        w_wvalid = 1'b1; w_wdata[0] = 32'hD0; w_wlast = 1'b0; wready = 1'b1;
        #1;
        vec++; if ({o_wr_state, o_awvalid, o_wvalid, o_wdata, o_wlast, o_wid, o_w_wready} !== {2'd2, 1'b0, 1'b1, 32'hD0, 1'b0, 4'd0, 1'b1}) begin errs++; $display("FAIL wr_beat0: got %h want %h", {o_wr_state, o_awvalid, o_wvalid, o_wdata, o_wlast, o_wid, o_w_wready}, {2'd2, 1'b0, 1'b1, 32'hD0, 1'b0, 4'd0, 1'b1}); end
        nxt();
        w_wdata[0] = 32'hD1; w_wlast = 1'b1;
        #1;
        vec++; if ({o_wr_state, o_wvalid, o_wdata, o_wlast} !== {2'd2, 1'b1, 32'hD1, 1'b1}) begin errs++; $display("FAIL wr_beat1: got %h want %h", {o_wr_state, o_wvalid, o_wdata, o_wlast}, {2'd2, 1'b1, 32'hD1, 1'b1}); end
        nxt();
        w_wvalid = 1'b0; w_wlast = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bid = 4'd1; w_bready = 1'b0;
        #1;
        vec++; if ({o_wr_state, o_wvalid, o_bready, o_w_bvalid} !== 5'b11010) begin errs++; $display("FAIL wr_stray_b: got %b want 11010", {o_wr_state, o_wvalid, o_bready, o_w_bvalid}); end
        nxt();
        bid = 4'd0;
        #1;
        vec++; if ({o_wr_state, o_bready, o_w_bvalid, o_w_bid} !== {2'd3, 1'b0, 1'b1, 4'd3}) begin errs++; $display("FAIL wr_b_stall: got %h want %h", {o_wr_state, o_bready, o_w_bvalid, o_w_bid}, {2'd3, 1'b0, 1'b1, 4'd3}); end
        nxt();
        w_bready = 1'b1;
        #1;
        vec++; if ({o_wr_state, o_bready, o_w_bvalid} !== 4'b1111) begin errs++; $display("FAIL wr_b_accept: got %b want 1111", {o_wr_state, o_bready, o_w_bvalid}); end
        nxt();
        bvalid = 1'b0; w_bready = 1'b0;
        #1;
        vec++; if ({o_wr_state, o_w_bvalid} !== 3'b000) begin errs++; $display("FAIL wr_idle: got %b want 000", {o_wr_state, o_w_bvalid}); end
    endtask

    task automatic test_reset_mid();
        nxt();
        m_arvalid = 2'b01; m_araddr[0] = 32'h600; m_arid[0] = 4'd9; arready = 1'b0;
        nxt();
        m_arvalid = 2'b00;
        w_awvalid = 1'b1; w_awaddr[0] = 32'h700; w_awid[0] = 4'd4;
        nxt();
        w_awvalid = 1'b0; awready = 1'b1;
        nxt();
        awready = 1'b0;
        w_wvalid = 1'b1; w_wdata[0] = 32'hE0; w_wlast = 1'b0; wready = 1'b1;
        #1;
        vec++; if ({o_wr_state, o_wvalid, o_arvalid, o_rd_busy} !== 6'b101101) begin errs++; $display("FAIL rstmid_pre: got %b want 101101", {o_wr_state, o_wvalid, o_arvalid, o_rd_busy}); end
        rst_n = 1'b0;
        #1;
        vec++; if ({o_wr_state, o_wvalid, o_w_wready, o_arvalid, o_rd_busy} !== 7'd0) begin errs++; $display("FAIL rstmid_async: got %b want 0000000", {o_wr_state, o_wvalid, o_w_wready, o_arvalid, o_rd_busy}); end
        nxt();
        rst_n = 1'b1;
        w_wvalid = 1'b0; wready = 1'b0;
        nxt();
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; m_rready = 2'b00;
        #1;
        vec++; if ({o_wr_state, o_m_rvalid, o_rready} !== 5'b00001) begin errs++; $display("FAIL rstmid_after: got %b want 00001", {o_wr_state, o_m_rvalid, o_rready}); end
        nxt();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_single();
        test_priority();
        test_out_of_order();
        test_stray();
        test_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
